// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants for the N:1 channel multiplexer family.
//   mode_e       : multiplexer operating mode (fixed select / round-robin)
//   N_MIN/N_MAX  : supported channel-count range
//   W_MIN/W_MAX  : supported data-width range
// -----------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 16;
    localparam int unsigned W_MIN = 1;
    localparam int unsigned W_MAX = 64;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin search: returns the first asserted request
// starting at index ptr and wrapping modulo N.
// Ports:
//   req         in   N   request vector
//   ptr         in   SW  search start index (always < N)
//   grant_valid out  1   at least one request asserted
//   grant_idx   out  SW  index of the winning request (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          grant_valid,
    output logic [SW-1:0] grant_idx
);

    localparam int unsigned NU = N;

    // ptr + off, folded back into 0..N-1; a single subtraction suffices
    // because ptr < N and off < N.
    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base,
                                               input int unsigned  off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NU) s = s - NU;
        return SW'(s);
    endfunction

    // Offsets are scanned from farthest to nearest so the last hit, which
    // wins, is the one closest to ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            if (req[wrap_idx(ptr, NU - 1 - k)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_idx(ptr, NU - 1 - k);
            end
        end
    end

endmodule

// File: rtl/mux_rr_nx1.sv
// -----------------------------------------------------------------------------
// mux_rr_nx1
// N-input to 1-output valid/ready multiplexer with a registered output stage.
// Channel selection is either fixed (sel) or round-robin starting at an
// internal pointer that advances past each granted channel.
// Ports:
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   mode       in   1    0 = fixed select via sel, 1 = round-robin
//   sel        in   SW   channel index for fixed mode (>= N never grants)
//   in_data    in   N*W  channel i at [i*W +: W]
//   in_valid   in   N    per-channel valid
//   in_ready   out  N    per-channel accept (combinational, one-hot or zero)
//   out_data   out  W    registered selected data
//   out_sel    out  SW   registered index of the supplying channel
//   out_valid  out  1    registered output valid
//   out_ready  in   1    downstream accept
// -----------------------------------------------------------------------------
module mux_rr_nx1
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam logic [SW:0]   N_EXT  = (SW+1)'(N);
    localparam logic [SW-1:0] IDX_MAX = SW'(N - 1);

    logic [SW-1:0] ptr;
    logic          load;
    logic          sel_ok;
    logic          arb_valid;
    logic [SW-1:0] arb_idx;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;
    logic          xfer;
    logic [W-1:0]  mux_data;
    logic [SW-1:0] ptr_next;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    assign load   = !out_valid || out_ready;
    assign sel_ok = ({1'b0, sel} < N_EXT);

    // sel_ok masks the in_valid lookup so an out-of-range sel never grants.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (mode == MODE_RR) begin
            grant_valid = arb_valid;
            grant_idx   = arb_idx;
        end else begin
            grant_valid = sel_ok && in_valid[sel];
            grant_idx   = sel;
        end
    end

    assign xfer = load && grant_valid;

    always_comb begin
        in_ready = '0;
        if (rst_n && xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        mux_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == SW'(i)) begin
                mux_data = in_data[i*W +: W];
            end
        end
    end

    // Explicit wrap keeps ptr inside 0..N-1 for non-power-of-two N.
    assign ptr_next = (grant_idx == IDX_MAX) ? '0 : grant_idx + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_sel   <= grant_idx;
                if (mode == MODE_RR) begin
                    ptr <= ptr_next;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_nx1
// Bench for mux_rr_nx1: one N=4/W=8 instance and one N=3/W=16 instance,
// directed scenarios followed by randomized traffic, all checked against a
// cycle-level reference model derived from the grant/load rules.
// -----------------------------------------------------------------------------
module tb_mux_rr_nx1;

    logic clk;
    logic rst_n;

    logic        mode_a, out_ready_a, out_valid_a;
    logic [1:0]  sel_a, out_sel_a;
    logic [31:0] in_data_a;
    logic [3:0]  in_valid_a, in_ready_a;
    logic [7:0]  out_data_a;

    logic        mode_b, out_ready_b, out_valid_b;
    logic [1:0]  sel_b, out_sel_b;
    logic [47:0] in_data_b;
    logic [2:0]  in_valid_b, in_ready_b;
    logic [15:0] out_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state per instance: [0] = A (N=4), [1] = B (N=3)
    bit          mv[2];
    logic [15:0] md[2];
    int          ms[2];
    int          mp[2];

    mux_rr_nx1 #(.N(4), .W(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode_a),
        .sel       (sel_a),
        .in_data   (in_data_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .out_data  (out_data_a),
        .out_sel   (out_sel_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a)
    );

    mux_rr_nx1 #(.N(3), .W(16)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode_b),
        .sel       (sel_b),
        .in_data   (in_data_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .out_data  (out_data_b),
        .out_sel   (out_sel_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Grant per the selection rules; -1 means no grant.
    function automatic int ref_grant(input int n, input logic mode, input int sel,
                                     input logic [15:0] valid, input int ptr);
        if (mode == 1'b0) begin
            if (sel < n && valid[sel]) return sel;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            if (valid[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
            ms[i] = 0;
            mp[i] = 0;
        end
    endtask

    // Entered just after a rising edge with inputs already driven; returns
    // 1 time unit after the next rising edge with outputs checked.
    task automatic step();
        int ga, gb;
        bit la, lb;
        logic [15:0] ra, rb;
        @(negedge clk);
        la = !mv[0] || out_ready_a;
        lb = !mv[1] || out_ready_b;
        ga = ref_grant(4, mode_a, int'(sel_a), 16'(in_valid_a), mp[0]);
        gb = ref_grant(3, mode_b, int'(sel_b), 16'(in_valid_b), mp[1]);
        ra = (la && ga >= 0) ? (16'd1 << ga) : 16'd0;
        rb = (lb && gb >= 0) ? (16'd1 << gb) : 16'd0;
        check("ready_a", 64'(in_ready_a), 64'(ra));
        check("ready_b", 64'(in_ready_b), 64'(rb));
        @(posedge clk);
        if (la) begin
            if (ga >= 0) begin
                mv[0] = 1'b1;
                md[0] = 16'(in_data_a[ga*8 +: 8]);
                ms[0] = ga;
                if (mode_a) mp[0] = (ga + 1) % 4;
            end else begin
                mv[0] = 1'b0;
            end
        end
        if (lb) begin
            if (gb >= 0) begin
                mv[1] = 1'b1;
                md[1] = in_data_b[gb*16 +: 16];
                ms[1] = gb;
                if (mode_b) mp[1] = (gb + 1) % 3;
            end else begin
                mv[1] = 1'b0;
            end
        end
        #1;
        check("valid_a", 64'(out_valid_a), 64'(mv[0]));
        check("data_a",  64'(out_data_a),  64'(md[0]));
        check("sel_a",   64'(out_sel_a),   64'(ms[0]));
        check("valid_b", 64'(out_valid_b), 64'(mv[1]));
        check("data_b",  64'(out_data_b),  64'(md[1]));
        check("sel_b",   64'(out_sel_b),   64'(ms[1]));
    endtask

    // Entered just after a rising edge: reset pulsed between edges, released
    // before the following falling edge.
    task automatic async_pulse();
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid_a", 64'(out_valid_a), 64'd0);
        check("rst_data_a",  64'(out_data_a),  64'd0);
        check("rst_sel_a",   64'(out_sel_a),   64'd0);
        check("rst_ready_a", 64'(in_ready_a),  64'd0);
        check("rst_valid_b", 64'(out_valid_b), 64'd0);
        check("rst_ready_b", 64'(in_ready_b),  64'd0);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 4; i++) in_data_a[i*8 +: 8] = 8'hA0 + 8'(i);
        for (int i = 0; i < 3; i++) in_data_b[i*16 +: 16] = 16'hB000 + 16'(i);
    endtask

    initial begin
        rst_n       = 1'b0;
        mode_a      = 1'b0; sel_a = '0; in_data_a = '0; in_valid_a = '0; out_ready_a = 1'b0;
        mode_b      = 1'b0; sel_b = '0; in_data_b = '0; in_valid_b = '0; out_ready_b = 1'b0;
        model_reset();

        // Reset state, with traffic offered while reset is held
        @(posedge clk); #1;
        mode_a = 1'b1; in_valid_a = 4'b1111; out_ready_a = 1'b1;
        mode_b = 1'b1; in_valid_b = 3'b111;  out_ready_b = 1'b1;
        fill_all();
        @(posedge clk); #1;
        check("reset_valid_a", 64'(out_valid_a), 64'd0);
        check("reset_data_a",  64'(out_data_a),  64'd0);
        check("reset_ready_a", 64'(in_ready_a),  64'd0);
        check("reset_ready_b", 64'(in_ready_b),  64'd0);

        // Round-robin, all valid: 0,1,2,3,0 on A and 0,1,2,0 on B
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                mode_b = 1'b0; sel_b = 2'd3;
            end
            step();
            check("rr_seq_sel_a",  64'(out_sel_a),  64'(k % 4));
            check("rr_seq_data_a", 64'(out_data_a), 64'(8'hA0 + 8'(k % 4)));
            if (k < 4) check("rr_seq_sel_b", 64'(out_sel_b), 64'(k % 3));
            else       check("b_sel3_nogrant", 64'(out_valid_b), 64'd0);
        end

        // Wrap: ptr=1 with channels 3 and 0 requesting
        in_valid_a = 4'b1001;
        step(); check("wrap_first",  64'(out_sel_a), 64'd3);
        step(); check("wrap_second", 64'(out_sel_a), 64'd0);
        in_valid_a = 4'b1111;
        step(); check("ptr_after_wrap", 64'(out_sel_a), 64'd1);

        // Fixed select on channel 2
        mode_a = 1'b0; sel_a = 2'd2; in_valid_a = 4'b0100;
        in_data_a = 32'h005C_0000;
        #2 check("fixed_ready", 64'(in_ready_a), 64'b0100);
        step();
        check("fixed_data", 64'(out_data_a), 64'h5C);
        check("fixed_sel",  64'(out_sel_a),  64'd2);
        in_valid_a = 4'b1011;
        #2 check("fixed_noready", 64'(in_ready_a), 64'd0);
        step();
        check("fixed_valid_fall", 64'(out_valid_a), 64'd0);

        // Backpressure: hold for 3 cycles then drain with a new load
        mode_a = 1'b1; in_valid_a = 4'b1111; fill_all();
        step();
        out_ready_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data_a = $urandom;
            step();
        end
        out_ready_a = 1'b1;
        step();
        step();

        // Asynchronous reset mid-stream, then first round-robin grant is ch0
        mode_b = 1'b1; in_valid_b = 3'b111;
        async_pulse();
        step();
        check("post_reset_sel_a",   64'(out_sel_a),   64'd0);
        check("post_reset_valid_a", 64'(out_valid_a), 64'd1);
        check("post_reset_sel_b",   64'(out_sel_b),   64'd0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            mode_a      = 1'($urandom);
            sel_a       = 2'($urandom);
            in_data_a   = $urandom;
            in_valid_a  = 4'($urandom);
            out_ready_a = ($urandom_range(0, 3) != 0);
            mode_b      = 1'($urandom);
            sel_b       = 2'($urandom);
            in_data_b   = {16'($urandom), $urandom};
            in_valid_b  = 3'($urandom);
            out_ready_b = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) async_pulse();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
